// File: rtl/labs_energy_seq.sv
// rtl/labs_energy_seq.sv - C_k correlator driver that accumulates sequence energy E = sum C_k^2
//
// Purpose:
//   Accepts one candidate binary sequence, issues one shifted operand pair per
//   cycle (k = 1..SEQ_WIDTH-1) to a pipelined C_k correlator, squares and
//   accumulates the returned C_k values, and hands the energy to the consumer.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready sequence handshake; in_seq bit=1 means +1, bit=0 means -1
//   ck_a/ck_b/ck_m    registered correlator operands and lane mask for shift k
//   ck_z              signed C_k from the correlator, CK_LATENCY cycles later
//   out_valid/ready   energy result handshake
//   out_energy        accumulated energy, saturating at 2^E_WIDTH-1
//   out_ovf           accumulator saturated (sticky until the next accept)
//   busy              high in every state except IDLE
`timescale 1ns/1ps

module labs_energy_seq #(
  parameter int SEQ_WIDTH  = 40,
  parameter int CK_LATENCY = 2,
  parameter int E_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEQ_WIDTH-1:0] in_seq,
  output logic [SEQ_WIDTH-1:0] ck_a,
  output logic [SEQ_WIDTH-1:0] ck_b,
  output logic [SEQ_WIDTH-1:0] ck_m,
  input  logic [7:0]           ck_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [E_WIDTH-1:0]   out_energy,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int KW = (SEQ_WIDTH > 2) ? $clog2(SEQ_WIDTH) : 1;
  // Sum width must hold both the E_WIDTH+1 accumulator and a full 16384 square.
  localparam int SW = (E_WIDTH + 1 > 16) ? E_WIDTH + 1 : 16;

  localparam logic [KW-1:0]         K_FIRST = KW'(1);
  localparam logic [KW-1:0]         K_LAST  = KW'(SEQ_WIDTH - 1);
  localparam logic [SEQ_WIDTH-1:0]  ONES    = '1;
  localparam logic [SW-1:0]         E_MAX   = {{(SW-E_WIDTH){1'b0}}, {E_WIDTH{1'b1}}};
  // Tag vector value when only the final issued tag remains, at the output stage.
  localparam logic [CK_LATENCY-1:0] TAG_TOP = CK_LATENCY'(1) << (CK_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [SEQ_WIDTH-1:0]   r_seq;
  logic [KW-1:0]          r_k;
  logic [SEQ_WIDTH-1:0]   r_ck_a;
  logic [SEQ_WIDTH-1:0]   r_ck_b;
  logic [SEQ_WIDTH-1:0]   r_ck_m;
  logic [CK_LATENCY-1:0]  r_tag;
  logic [E_WIDTH-1:0]     r_acc;
  logic                   r_ovf;

  logic                   w_issue;
  logic                   w_tag_out;
  logic                   w_accept;
  logic [KW-1:0]          w_k_next;
  logic signed [15:0]     w_prod;
  logic [15:0]            w_sq;
  logic [SW-1:0]          w_sum;
  logic                   w_sat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    w_issue   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        if (r_k == K_LAST) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No new tags enter while draining, so the pipe holding only the
        // top bit means the last result is being accumulated this cycle.
        if (r_tag == TAG_TOP) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_tag_out = r_tag[CK_LATENCY-1];
  assign w_k_next  = r_k + K_FIRST;

  // Squared in 16 bits so that -128 * -128 = 16384 stays positive.
  assign w_prod = $signed(ck_z) * $signed(ck_z);
  assign w_sq   = w_prod;
  assign w_sum  = SW'(r_acc) + SW'(w_sq);
  assign w_sat  = (w_sum > E_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq  <= '0;
      r_k    <= '0;
      r_ck_a <= '0;
      r_ck_b <= '0;
      r_ck_m <= '0;
      r_tag  <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      // A tag travels alongside each issued operand pair; it reaches the top
      // stage in the cycle the matching ck_z is presented.
      r_tag <= (r_tag << 1) | CK_LATENCY'(w_issue);

      if (w_tag_out) begin
        if (w_sat) begin
          r_acc <= E_MAX[E_WIDTH-1:0];
          r_ovf <= 1'b1;
        end else begin
          r_acc <= w_sum[E_WIDTH-1:0];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_seq  <= in_seq;
            r_k    <= K_FIRST;
            r_ck_a <= in_seq;
            r_ck_b <= in_seq >> 1;
            r_ck_m <= ONES >> 1;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (r_k == K_LAST) begin
            r_ck_a <= '0;
            r_ck_b <= '0;
            r_ck_m <= '0;
          end else begin
            r_k    <= w_k_next;
            r_ck_a <= r_seq;
            r_ck_b <= r_seq >> w_k_next;
            r_ck_m <= ONES >> w_k_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ck_a       = r_ck_a;
  assign ck_b       = r_ck_b;
  assign ck_m       = r_ck_m;
  assign out_energy = r_acc;
  assign out_ovf    = r_ovf;

endmodule

// File: tb/tb_labs_energy_seq.sv
// tb/tb_labs_energy_seq.sv - self-checking bench for labs_energy_seq with a behavioural correlator
`timescale 1ns/1ps

module tb_labs_energy_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // instance 0: N=40 L=2 E=16
  logic        iv0, rdy0, ov0, or0, ovf0, busy0;
  logic [39:0] sq0, a0, b0, m0;
  logic [7:0]  z0;
  logic [15:0] e0;
  // instance 1: N=4 L=2 E=16
  logic        iv1, rdy1, ov1, or1, ovf1, busy1;
  logic [3:0]  sq1, a1, b1, m1;
  logic [7:0]  z1;
  logic [15:0] e1;
  // instance 2: N=40 L=2 E=14
  logic        iv2, rdy2, ov2, or2, ovf2, busy2;
  logic [39:0] sq2, a2, b2, m2;
  logic [7:0]  z2;
  logic [13:0] e2;

  labs_energy_seq #(.SEQ_WIDTH(40), .CK_LATENCY(2), .E_WIDTH(16)) u_main (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .in_seq(sq0),
    .ck_a(a0), .ck_b(b0), .ck_m(m0), .ck_z(z0), .out_valid(ov0), .out_ready(or0),
    .out_energy(e0), .out_ovf(ovf0), .busy(busy0));

  labs_energy_seq #(.SEQ_WIDTH(4), .CK_LATENCY(2), .E_WIDTH(16)) u_small (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_seq(sq1),
    .ck_a(a1), .ck_b(b1), .ck_m(m1), .ck_z(z1), .out_valid(ov1), .out_ready(or1),
    .out_energy(e1), .out_ovf(ovf1), .busy(busy1));

  labs_energy_seq #(.SEQ_WIDTH(40), .CK_LATENCY(2), .E_WIDTH(14)) u_e14 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .in_seq(sq2),
    .ck_a(a2), .ck_b(b2), .ck_m(m2), .ck_z(z2), .out_valid(ov2), .out_ready(or2),
    .out_energy(e2), .out_ovf(ovf2), .busy(busy2));

  // Behavioural correlator: two-stage delay of the masked agreement count.
  function automatic logic [7:0] corr(input logic [39:0] a, input logic [39:0] b,
                                      input logic [39:0] m);
    int acc;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (m[i]) acc += (a[i] == b[i]) ? 1 : -1;
    end
    return 8'(acc);
  endfunction

  logic [7:0] zp0 [2];
  logic [7:0] zp1 [2];
  logic [7:0] zp2 [2];

  always_ff @(posedge clk) begin
    zp0[0] <= corr(a0, b0, m0);
    zp0[1] <= zp0[0];
    zp1[0] <= corr({36'b0, a1}, {36'b0, b1}, {36'b0, m1});
    zp1[1] <= zp1[0];
    zp2[0] <= corr(a2, b2, m2);
    zp2[1] <= zp2[0];
  end

  assign z0 = zp0[1];
  assign z1 = zp1[1];
  assign z2 = zp2[1];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic get_rdy(input int d);
    case (d)
      0: return rdy0;
      1: return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_ovf(input int d);
    case (d)
      0: return ovf0;
      1: return ovf1;
      default: return ovf2;
    endcase
  endfunction

  function automatic logic [15:0] get_e(input int d);
    case (d)
      0: return e0;
      1: return e1;
      default: return {2'b00, e2};
    endcase
  endfunction

  function automatic logic [39:0] get_m(input int d);
    case (d)
      0: return m0;
      1: return {36'b0, m1};
      default: return m2;
    endcase
  endfunction

  function automatic logic [39:0] get_a(input int d);
    case (d)
      0: return a0;
      1: return {36'b0, a1};
      default: return a2;
    endcase
  endfunction

  task automatic set_in(input int d, input logic v, input logic [39:0] s);
    case (d)
      0: begin iv0 = v; sq0 = s; end
      1: begin iv1 = v; sq1 = s[3:0]; end
      default: begin iv2 = v; sq2 = s; end
    endcase
  endtask

  task automatic set_ordy(input int d, input logic v);
    case (d)
      0: or0 = v;
      1: or1 = v;
      default: or2 = v;
    endcase
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge where
  // out_valid is first seen (or when the cycle budget runs out).
  task automatic run(input int d, input logic [39:0] s, input string tag,
                     input logic [39:0] exp_m1, input int exp_lat,
                     output logic [15:0] e, output logic ovf);
    int cnt;
    set_in(d, 1'b1, s);
    chk({tag, " in_ready before accept"}, get_rdy(d), 1);
    @(posedge clk);
    @(negedge clk);
    set_in(d, 1'b0, s);
    chk({tag, " ck_m at T+1"}, get_m(d), exp_m1);
    chk({tag, " ck_a at T+1"}, get_a(d), s);
    chk({tag, " busy at T+1"}, get_busy(d), 1);
    chk({tag, " energy cleared at T+1"}, get_e(d), 0);
    chk({tag, " ovf cleared at T+1"}, get_ovf(d), 0);
    cnt = 1;
    while (!get_ov(d) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " latency"}, cnt, exp_lat);
    e   = get_e(d);
    ovf = get_ovf(d);
  endtask

  task automatic drain_out(input int d, input string tag);
    set_ordy(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(d, 1'b0);
    chk({tag, " in_ready after output"}, get_rdy(d), 1);
    chk({tag, " out_valid after output"}, get_ov(d), 0);
  endtask

  typedef struct {
    int          d;
    logic [39:0] seq;
    logic [39:0] m1;
    int          lat;
    logic [15:0] e;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [15:0] e;
    logic        ovf;

    vecs[0] = '{0, 40'hFF_FFFF_FFFF, 40'h7F_FFFF_FFFF, 42, 16'd20540, 1'b0};
    vecs[1] = '{0, 40'hAA_AAAA_AAAA, 40'h7F_FFFF_FFFF, 42, 16'd20540, 1'b0};
    vecs[2] = '{0, 40'h00_0000_0000, 40'h7F_FFFF_FFFF, 42, 16'd20540, 1'b0};
    vecs[3] = '{0, 40'h00_0000_0001, 40'h7F_FFFF_FFFF, 42, 16'd17576, 1'b0};
    vecs[4] = '{1, 40'hB,            40'h7,            6,  16'd2,     1'b0};
    vecs[5] = '{1, 40'hF,            40'h7,            6,  16'd14,    1'b0};
    vecs[6] = '{2, 40'hFF_FFFF_FFFF, 40'h7F_FFFF_FFFF, 42, 16'd16383, 1'b1};
    vecs[7] = '{2, 40'hAA_AAAA_AAAA, 40'h7F_FFFF_FFFF, 42, 16'd16383, 1'b1};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, 40'h0);
      set_ordy(d, 1'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset in_ready d%0d", d), get_rdy(d), 1);
      chk($sformatf("reset out_valid d%0d", d), get_ov(d), 0);
      chk($sformatf("reset energy d%0d", d), get_e(d), 0);
      chk($sformatf("reset ovf d%0d", d), get_ovf(d), 0);
      chk($sformatf("reset busy d%0d", d), get_busy(d), 0);
      chk($sformatf("reset ck_m d%0d", d), get_m(d), 0);
    end

    for (int v = 0; v < 8; v++) begin
      run(vecs[v].d, vecs[v].seq, $sformatf("vec%0d", v), vecs[v].m1, vecs[v].lat, e, ovf);
      chk($sformatf("vec%0d energy", v), e, vecs[v].e);
      chk($sformatf("vec%0d ovf", v), ovf, vecs[v].ovf);
      drain_out(vecs[v].d, $sformatf("vec%0d", v));
    end

    // Backpressure: result held, new sequence offered but not taken while DONE.
    run(0, 40'hFF_FFFF_FFFF, "bp", 40'h7F_FFFF_FFFF, 42, e, ovf);
    chk("bp energy", e, 20540);
    set_in(0, 1'b1, 40'h00_0000_0001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold energy c%0d", i), get_e(0), 20540);
      chk($sformatf("bp in_ready low c%0d", i), get_rdy(0), 0);
      chk($sformatf("bp out_valid c%0d", i), get_ov(0), 1);
    end
    drain_out(0, "bp");
    run(0, 40'h00_0000_0001, "b2b", 40'h7F_FFFF_FFFF, 42, e, ovf);
    chk("b2b energy", e, 17576);
    chk("b2b ovf", ovf, 0);
    drain_out(0, "b2b");

    // Reset in the middle of ISSUE.
    set_in(0, 1'b1, 40'hAA_AAAA_AAAA);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 40'h0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready", get_rdy(0), 1);
    chk("midrst busy", get_busy(0), 0);
    chk("midrst out_valid", get_ov(0), 0);
    chk("midrst energy", get_e(0), 0);
    chk("midrst ovf", get_ovf(0), 0);
    chk("midrst ck_m", get_m(0), 0);
    chk("midrst ck_a", get_a(0), 0);
    run(0, 40'hFF_FFFF_FFFF, "postrst", 40'h7F_FFFF_FFFF, 42, e, ovf);
    chk("postrst energy", e, 20540);
    chk("postrst ovf", ovf, 0);
    drain_out(0, "postrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/labs_energy_seq.md
Name: labs_energy_seq

Overview:
- Initiator/driver side of the C_k correlator interface.
- Accepts one candidate binary sequence over a valid/ready handshake.
- Issues one shifted operand pair per cycle, for k = 1..SEQ_WIDTH-1, into the pipelined C_k calculator.
- Collects the returned C_k values after a fixed latency and accumulates energy E = sum C_k^2, which it returns to the search controller over a second valid/ready handshake.

Parameters:
- SEQ_WIDTH, 40: sequence length N in bits (N >= 2).
- CK_LATENCY, 2: cycles from ck_a/ck_b/ck_m driven to the matching ck_z at the input (>= 1).
- E_WIDTH, 16: width of the energy accumulator/output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_seq valid.
- in_ready  out  1  block can accept a sequence.
- in_seq  in  SEQ_WIDTH  candidate sequence; bit=1 means +1, bit=0 means -1.
- ck_a  out  SEQ_WIDTH  correlator operand A (registered).
- ck_b  out  SEQ_WIDTH  correlator operand B (registered).
- ck_m  out  SEQ_WIDTH  lane mask (registered).
- ck_z  in  8  signed C_k returned by the correlator.
- out_valid  out  1  energy result valid.
- out_ready  in  1  consumer accepts result.
- out_energy  out  E_WIDTH  accumulated energy.
- out_ovf  out  1  accumulator saturated.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Correlator contract: ck_z = sum over bits i with ck_m[i]=1 of (+1 if ck_a[i]==ck_b[i], else -1), as 8-bit two's complement, CK_LATENCY cycles after the operands.
- For shift k:
  - ck_a = seq.
  - ck_b = seq >> k (zero-filled).
  - ck_m = bits [N-1-k:0] set.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1; ck_a/ck_b/ck_m=0.
  - Handshake at cycle T: latch in_seq, clear accumulator and ovf, k<=1, go to ISSUE.
- ISSUE:
  - Cycles T+1 .. T+N-1: drive the operands for k, set the issue tag, k++.
  - After k=N-1 is issued, go to DRAIN; operands return to 0.
- Tag pipeline:
  - A CK_LATENCY-deep shift register of valid tags.
  - When a tag emerges, the result for shift k is sampled from ck_z at cycle T+k+CK_LATENCY.
  - That sample adds ck_z*ck_z (signed 8x8, 15-bit unsigned) to the accumulator.
- DRAIN: when the last tag has emerged and been accumulated (cycle T+N-1+CK_LATENCY), go to DONE.
- DONE:
  - out_valid=1 from cycle T+N+CK_LATENCY.
  - out_energy and out_ovf are held stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE; in_ready=1 the next cycle.
  - No input is accepted in the same cycle as output.
- Latency: handshake to out_valid is N+CK_LATENCY cycles (N=40, L=2: 42). Throughput is one sequence per N+CK_LATENCY+1 cycles minimum.
- Arithmetic:
  - Accumulate in E_WIDTH+1 bits.
  - On exceeding 2^E_WIDTH-1, clamp to 2^E_WIDTH-1 and set out_ovf (sticky until the next accept).
  - The ck_z value -128 is squared as 16384.
- in_valid while busy is ignored; in_seq is not re-sampled.
- Reset (any state, including mid-ISSUE/DRAIN):
  - Next cycle: state IDLE.
  - in_ready=1; out_valid=0, out_energy=0, out_ovf=0, busy=0.
  - ck_a/ck_b/ck_m=0; tag pipeline cleared.
  - In-flight ck_z values are never accumulated.
- ck_z is ignored whenever no tag emerges.

Test Plan (bench provides a behavioural correlator model with latency CK_LATENCY):
- All-ones, N=40, L=2: accept at T -> ck_m at T+1 = 40'h7F_FFFF_FFFF, out_valid at T+42, out_energy=20540, out_ovf=0.
- Alternating 0xAAAAAAAAAA, N=40 -> C_k=(-1)^k(40-k), out_energy=20540. Also exercises negative ck_z.
- SEQ_WIDTH=4, seq 4'b1011 (+1,+1,-1,+1 from bit0) -> C1=-1, C2=0, C3=+1, out_energy=2, out_valid 6 cycles after accept.
- E_WIDTH=14, all-ones N=40 -> out_energy=16383, out_ovf=1. Next sequence 0xAAAAAAAAAA with E_WIDTH=14 -> ovf cleared on accept, then set again.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> energy held, in_ready=0, in_valid ignored. out_ready=1 -> handshake completes, in_ready=1 the next cycle, and a back-to-back sequence is accepted correctly.
- rst pulsed at T+20 during ISSUE -> all outputs at reset values the next cycle. Model results still in flight are not accumulated. A following all-ones run returns exactly 20540.
